// File: rtl/vga_pkg.sv
// Shared constants for the score overlay: digit codes, segment region encoding
// and the colour theme table.
package vga_pkg;

  localparam logic [3:0] DIG_DASH  = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd11;

  // Regions 0..8 are the segment indices themselves.
  localparam logic [3:0] REG_NONE = 4'd15;

  localparam logic [13:0] VALUE_MAX = 14'd9999;

  localparam logic [11:0] THEME0_BG = 12'h000;
  localparam logic [11:0] THEME0_FG = 12'hFFF;
  localparam logic [11:0] THEME1_BG = 12'hFFF;
  localparam logic [11:0] THEME1_FG = 12'h000;
  localparam logic [11:0] THEME2_BG = 12'hE7D;
  localparam logic [11:0] THEME2_FG = 12'h8F0;

  typedef enum logic [1:0] {
    B2B_IDLE,
    B2B_SHIFT,
    B2B_DONE
  } b2b_state_t;

  function automatic logic [11:0] theme_bg(input logic [3:0] theme);
    case (theme)
      4'd1:    return THEME1_BG;
      4'd2:    return THEME2_BG;
      default: return THEME0_BG;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: 14-bit binary in (saturated at 9999),
// four BCD digits out with a one-cycle done pulse.
module bin2bcd_seq
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bin,
  input  logic        bin_valid,
  output logic        bin_ready,
  output logic [15:0] bcd,
  output logic        done
);

  b2b_state_t  state;
  logic [29:0] sr;
  logic [3:0]  iter;

  function automatic logic [29:0] dabble_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[14+4*i +: 4] >= 4'd5) t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  assign bcd = sr[29:14];

  // NOTE: state registers use <= so every branch sees the pre-edge values;
  // a blocking = here would let later statements observe half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= B2B_IDLE;
      bin_ready <= 1'b1;
      done      <= 1'b0;
      sr        <= '0;
      iter      <= '0;
    end else begin
      case (state)
        B2B_IDLE: begin
          done <= 1'b0;
          if (bin_valid && bin_ready) begin
            sr        <= {16'd0, (bin > VALUE_MAX) ? VALUE_MAX : bin};
            iter      <= '0;
            bin_ready <= 1'b0;
            state     <= B2B_SHIFT;
          end
        end
        B2B_SHIFT: begin
          sr   <= dabble_step(sr);
          iter <= iter + 4'd1;
          if (iter == 4'd13) begin
            done  <= 1'b1;
            state <= B2B_DONE;
          end
        end
        B2B_DONE: begin
          done      <= 1'b0;
          bin_ready <= 1'b1;
          state     <= B2B_IDLE;
        end
        default: begin
          done      <= 1'b0;
          bin_ready <= 1'b1;
          state     <= B2B_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_score_ctrl.sv
// Score overlay sequencer: converts values to BCD, commits digits at frame
// start, maps scan position to digit slot/segment and selects the pixel colour.
module vga_score_ctrl
  import vga_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int X0         = 400,
  parameter int Y0         = 16,
  parameter int DIGIT_W    = 32,
  parameter int DIGIT_H    = 48,
  parameter int GAP        = 8,
  parameter int SEG_T      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        blank_lz,
  input  logic [3:0]  theme,
  input  logic        frame_start,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  output logic [3:0]  num,
  input  logic [11:0] seg0,
  input  logic [11:0] seg1,
  input  logic [11:0] seg2,
  input  logic [11:0] seg3,
  input  logic [11:0] seg4,
  input  logic [11:0] seg5,
  input  logic [11:0] seg6,
  input  logic [11:0] seg7,
  input  logic [11:0] seg8,
  output logic [11:0] pixel,
  output logic        in_score
);

  localparam logic [9:0] Y0_L = 10'(Y0);
  localparam logic [9:0] W_L  = 10'(DIGIT_W);
  localparam logic [9:0] H_L  = 10'(DIGIT_H);
  localparam logic [9:0] T_L  = 10'(SEG_T);
  localparam logic [9:0] M_L  = 10'(DIGIT_H / 2 - SEG_T / 2);

  logic [15:0]          bcd;
  logic                 bcd_done;
  logic [3:0][3:0]      pending;
  logic [3:0][3:0]      shown;
  logic [3:0]           digit_code [NUM_DIGITS];
  logic                 zero_run;
  logic                 in_cell_d, in_cell_q;
  logic [3:0]           num_d, region_d, region_q;
  logic [9:0]           base, lx, ly;
  logic                 v_in;
  logic [3:0]           theme_q;
  logic [11:0]          seg_sel;

  bin2bcd_seq u_b2b (
    .clk       (clk),
    .rst       (rst),
    .bin       (value),
    .bin_valid (value_valid),
    .bin_ready (value_ready),
    .bcd       (bcd),
    .done      (bcd_done)
  );

  // shown samples pending as it was before this edge, so a DONE landing on
  // frame_start is only displayed from the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      shown   <= '0;
    end else begin
      if (bcd_done)    pending <= bcd;
      if (frame_start) shown   <= pending;
    end
  end

  function automatic logic [3:0] seg_region(input logic [9:0] x, input logic [9:0] y);
    if (y < T_L)                       return 4'd0;
    else if (y >= H_L - T_L)           return 4'd3;
    else if (y >= M_L && y < M_L + T_L) begin
      if (x < T_L)                     return 4'd7;
      else if (x >= W_L - T_L)         return 4'd8;
      else                             return 4'd6;
    end
    else if (x < T_L)                  return (y < M_L) ? 4'd5 : 4'd4;
    else if (x >= W_L - T_L)           return (y < M_L) ? 4'd1 : 4'd2;
    else                               return REG_NONE;
  endfunction

  // NOTE: every variable gets a default before the branches so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    zero_run = blank_lz;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_code[k] = shown[NUM_DIGITS-1-k];
      if (zero_run && shown[NUM_DIGITS-1-k] == 4'd0 && k != NUM_DIGITS - 1)
        digit_code[k] = DIG_BLANK;
      else
        zero_run = 1'b0;
    end
  end

  always_comb begin
    in_cell_d = 1'b0;
    num_d     = DIG_BLANK;
    lx        = '0;
    base      = '0;
    ly        = v_cnt - Y0_L;
    v_in      = (v_cnt >= Y0_L) && (v_cnt < Y0_L + H_L);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      base = 10'(X0 + k * (DIGIT_W + GAP));
      if (v_in && h_cnt >= base && h_cnt < base + W_L) begin
        in_cell_d = 1'b1;
        num_d     = digit_code[k];
        lx        = h_cnt - base;
      end
    end
    region_d = in_cell_d ? seg_region(lx, ly) : REG_NONE;
  end

  // Theme is staged alongside position so a change reaches pixel in 2 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      num       <= DIG_BLANK;
      region_q  <= REG_NONE;
      in_cell_q <= 1'b0;
      theme_q   <= '0;
    end else begin
      num       <= num_d;
      region_q  <= region_d;
      in_cell_q <= in_cell_d;
      theme_q   <= theme;
    end
  end

  always_comb begin
    seg_sel = theme_bg(theme_q);
    case (region_q)
      4'd0:    seg_sel = seg0;
      4'd1:    seg_sel = seg1;
      4'd2:    seg_sel = seg2;
      4'd3:    seg_sel = seg3;
      4'd4:    seg_sel = seg4;
      4'd5:    seg_sel = seg5;
      4'd6:    seg_sel = seg6;
      4'd7:    seg_sel = seg7;
      4'd8:    seg_sel = seg8;
      default: seg_sel = theme_bg(theme_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel    <= 12'h000;
      in_score <= 1'b0;
    end else begin
      pixel    <= in_cell_q ? seg_sel : theme_bg(theme_q);
      in_score <= in_cell_q;
    end
  end

endmodule

// File: tb/tb_vga_score_ctrl.sv
// Directed bench for vga_score_ctrl with a combinational stand-in for the
// nine-segment renderer (lit segments FFF, unlit 000).
module tb_vga_score_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        blank_lz;
  logic [3:0]  theme;
  logic        frame_start;
  logic [9:0]  h_cnt, v_cnt;
  logic [3:0]  num;
  logic [11:0] seg [9];
  logic [11:0] pixel;
  logic        in_score;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_score_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .blank_lz    (blank_lz),
    .theme       (theme),
    .frame_start (frame_start),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .num         (num),
    .seg0        (seg[0]),
    .seg1        (seg[1]),
    .seg2        (seg[2]),
    .seg3        (seg[3]),
    .seg4        (seg[4]),
    .seg5        (seg[5]),
    .seg6        (seg[6]),
    .seg7        (seg[7]),
    .seg8        (seg[8]),
    .pixel       (pixel),
    .in_score    (in_score)
  );

  // Segments: 0 top, 1 upper right, 2 lower right, 3 bottom, 4 lower left,
  // 5 upper left, 6 middle, 7 middle-left stub, 8 middle-right stub.
  function automatic logic [8:0] seg_mask(input logic [3:0] d);
    case (d)
      4'd0:    return 9'h1BF;
      4'd1:    return 9'h106;
      4'd2:    return 9'h1DB;
      4'd3:    return 9'h1CF;
      4'd4:    return 9'h1E6;
      4'd5:    return 9'h1ED;
      4'd6:    return 9'h1FD;
      4'd7:    return 9'h107;
      4'd8:    return 9'h1FF;
      4'd9:    return 9'h1EF;
      4'd10:   return 9'h1C0;
      default: return 9'h000;
    endcase
  endfunction

  always_comb begin
    logic [8:0] m;
    m = seg_mask(num);
    for (int i = 0; i < 9; i++) seg[i] = m[i] ? 12'hFFF : 12'h000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic [3:0] exp_num, input logic [11:0] exp_pix,
                       input logic exp_in);
    @(negedge clk);
    h_cnt = 10'(x);
    v_cnt = 10'(y);
    @(posedge clk); #1;
    check({tag, ".num"}, 32'(num), 32'(exp_num));
    @(posedge clk); #1;
    check({tag, ".pixel"}, 32'(pixel), 32'(exp_pix));
    check({tag, ".in_score"}, 32'(in_score), 32'(exp_in));
  endtask

  // Returns after the handshake edge, with value_valid dropped at the next negedge.
  task automatic send(input logic [13:0] v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!value_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    value       = v;
    value_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (value_ready) break;
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; value = '0; value_valid = 1'b0; blank_lz = 1'b0;
    theme = 4'd0; frame_start = 1'b0; h_cnt = '0; v_cnt = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(value_ready), 32'd1);
    check("rst.num", 32'(num), 32'd11);
    check("rst.pixel", 32'(pixel), 32'h000);
    check("rst.in_score", 32'(in_score), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1234: latency, then slot 0 top bar still shows committed "0"
    send(14'd1234);
    check("hs.ready_low", 32'(value_ready), 32'd0);
    wait_ready(n);
    check("conv.latency", 32'(n), 32'd15);
    probe("s1.top0", 410, 17, 4'd0, 12'hFFF, 1'b1);
    pulse_frame();
    probe("s1.d0", 416, 37, 4'd1, 12'h000, 1'b1);
    probe("s1.d1", 456, 37, 4'd2, 12'hFFF, 1'b1);
    probe("s1.d2", 496, 37, 4'd3, 12'hFFF, 1'b1);
    probe("s1.d3", 536, 37, 4'd4, 12'hFFF, 1'b1);

    // 42 with leading-zero blanking
    blank_lz = 1'b1;
    send(14'd42);
    wait_ready(n);
    pulse_frame();
    probe("s2.d0", 410, 17, 4'd11, 12'h000, 1'b1);
    probe("s2.d1", 450, 17, 4'd11, 12'h000, 1'b1);
    probe("s2.d2ur", 511, 26, 4'd4, 12'hFFF, 1'b1);
    probe("s2.d2top", 490, 17, 4'd4, 12'h000, 1'b1);
    probe("s2.d3ll", 520, 51, 4'd2, 12'hFFF, 1'b1);

    // 0 blanked: only the last slot lit
    send(14'd0);
    wait_ready(n);
    pulse_frame();
    probe("s3.mid", 536, 37, 4'd0, 12'h000, 1'b1);
    probe("s3.stub", 520, 37, 4'd0, 12'hFFF, 1'b1);
    probe("s3.d2", 490, 37, 4'd11, 12'h000, 1'b1);

    // Saturation, and a second offer during SHIFT is ignored
    blank_lz = 1'b0;
    send(14'd12000);
    value       = 14'd5555;
    value_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("s4.busy_ready", 32'(value_ready), 32'd0);
    end
    @(negedge clk);
    value_valid = 1'b0;
    wait_ready(n);
    check("s4.ready_back", 32'(value_ready), 32'd1);
    pulse_frame();
    probe("s4.d0", 410, 17, 4'd9, 12'hFFF, 1'b1);
    probe("s4.d1", 450, 17, 4'd9, 12'hFFF, 1'b1);
    probe("s4.d3", 536, 37, 4'd9, 12'hFFF, 1'b1);

    // DONE on the same edge as frame_start: old digits remain this frame
    send(14'd5678);
    repeat (14) @(posedge clk);
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk); #1;
    check("s5.align_ready", 32'(value_ready), 32'd1);
    @(negedge clk);
    frame_start = 1'b0;
    probe("s5.old", 536, 37, 4'd9, 12'hFFF, 1'b1);
    pulse_frame();
    probe("s5.new3", 536, 37, 4'd8, 12'hFFF, 1'b1);
    probe("s5.new0", 410, 61, 4'd5, 12'hFFF, 1'b1);

    // Reset in the middle of SHIFT
    send(14'd7777);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    blank_lz = 1'b1;
    @(posedge clk); #1;
    check("s6.ready", 32'(value_ready), 32'd1);
    check("s6.num", 32'(num), 32'd11);
    check("s6.pixel", 32'(pixel), 32'h000);
    @(negedge clk);
    rst = 1'b0;
    probe("s6.d3", 520, 37, 4'd0, 12'hFFF, 1'b1);
    probe("s6.d2", 490, 37, 4'd11, 12'h000, 1'b1);
    repeat (20) @(posedge clk);
    pulse_frame();
    probe("s6.after", 536, 37, 4'd0, 12'h000, 1'b1);

    // Cell edges
    probe("edge.bot", 431, 63, 4'd11, 12'h000, 1'b1);
    probe("edge.above", 400, 15, 4'd11, 12'h000, 1'b0);
    probe("edge.below", 400, 64, 4'd11, 12'h000, 1'b0);

    // Theme 2: gap pixel, region-none pixel, then theme latency
    theme = 4'd2;
    probe("s7.gap", 433, 21, 4'd11, 12'hE7D, 1'b0);
    probe("s7.none", 410, 26, 4'd11, 12'hE7D, 1'b1);
    probe("s7.gap2", 433, 21, 4'd11, 12'hE7D, 1'b0);
    @(negedge clk);
    theme = 4'd1;
    @(posedge clk); #1;
    check("s7.theme_d1", 32'(pixel), 32'hE7D);
    @(posedge clk); #1;
    check("s7.theme_d2", 32'(pixel), 32'hFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
